// File: rtl/dma_pkg.sv
// Shared definitions for the DMA command queue: descriptor field layout,
// command codes and FSM state encoding.
package dma_pkg;

  localparam int unsigned CNT_MSB = 31;
  localparam int unsigned CNT_LSB = 26;
  localparam int unsigned SRC_MSB = 25;
  localparam int unsigned SRC_LSB = 13;
  localparam int unsigned DST_MSB = 12;
  localparam int unsigned DST_LSB = 0;

  localparam int unsigned DESC_W  = 32;
  localparam int unsigned CMD_W   = 2;
  localparam int unsigned ENTRY_W = DESC_W + CMD_W;

  localparam logic [CMD_W-1:0] CMD_MOVE1 = 2'b00;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StIssue = 2'b10,
    StGap   = 2'b11
  } dma_state_e;

  function automatic logic [CNT_MSB-CNT_LSB:0] desc_count(input logic [DESC_W-1:0] desc);
    return desc[CNT_MSB:CNT_LSB];
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Circular descriptor FIFO; pointers carry one extra wrap bit so that full,
// empty and occupancy all fall out of the pointer pair.
module dma_desc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

endmodule

// File: rtl/dma_cmd_queue.sv
// Descriptor queue in front of the DMA engine: buffers pushed descriptors and
// issues them one at a time over the dreq/ddone handshake with a timeout.
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 8,
  localparam int unsigned LW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push_valid,
  input  logic [31:0]   i_push_desc,
  input  logic [1:0]    i_push_cmd,
  output logic          o_push_ready,
  output logic [31:0]   o_dma_desc,
  output logic [1:0]    o_dma_cmd,
  output logic          o_dreq,
  input  logic          i_ddone,
  output logic          o_busy,
  output logic [LW-1:0] o_level,
  output logic [CW-1:0] o_done_cnt,
  output logic [1:0]    o_err,
  input  logic          i_err_clr
);

  localparam int unsigned  TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TmoOne  = TW'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  dma_state_e         r_state;
  dma_state_e         w_state_d;
  logic [TW-1:0]      r_tmo;
  logic [CW-1:0]      r_done_cnt;
  logic [1:0]         r_err;
  logic [1:0]         w_err_d;
  logic [31:0]        r_dma_desc;
  logic [1:0]         r_dma_cmd;

  logic               w_push_acc;
  logic               w_zero_cnt;
  logic               w_fifo_push;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic               w_tmo_hit;
  logic               w_done;
  logic               w_tmo;
  logic               w_pop;
  logic               w_load;

  // A zero-count descriptor is accepted off the bus but never enters the FIFO.
  assign w_push_acc  = i_push_valid && o_push_ready;
  assign w_zero_cnt  = (desc_count(i_push_desc) == '0);
  assign w_fifo_push = w_push_acc && !w_zero_cnt;
  assign w_drop      = w_push_acc && w_zero_cnt;
  assign w_pop       = w_done || w_tmo;
  assign w_tmo_hit   = (r_tmo == TmoLast);

  dma_desc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_fifo_push),
    .i_push_data ({i_push_cmd, i_push_desc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (o_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_d = StLoad;
      StLoad:  w_state_d = StIssue;
      StIssue: if (i_ddone || w_tmo_hit) w_state_d = StGap;
      StGap:   if (!i_ddone) w_state_d = w_empty ? StIdle : StLoad;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_dreq = 1'b0;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      StIssue: begin
        o_dreq = 1'b1;
        w_done = i_ddone;
        w_tmo  = !i_ddone && w_tmo_hit;
      end
      default: begin
      end
    endcase
    // Capture the head on entry to LOAD so it is stable a full cycle before dreq.
    w_load = (w_state_d == StLoad) && (r_state != StLoad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == StLoad) begin
      r_tmo <= '0;
    end else if (r_state == StIssue) begin
      r_tmo <= r_tmo + TmoOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma_desc <= '0;
      r_dma_cmd  <= '0;
    end else if (w_load) begin
      r_dma_desc <= w_head[DESC_W-1:0];
      r_dma_cmd  <= w_head[ENTRY_W-1:DESC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (w_done) begin
      r_done_cnt <= r_done_cnt + CntOne;
    end
  end

  // Setting an error bit takes priority over a same-cycle clear.
  always_comb begin
    w_err_d[0] = w_tmo  || (r_err[0] && !i_err_clr);
    w_err_d[1] = w_drop || (r_err[1] && !i_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_d;
    end
  end

  assign o_push_ready = !w_full;
  assign o_dma_desc   = r_dma_desc;
  assign o_dma_cmd    = r_dma_cmd;
  assign o_done_cnt   = r_done_cnt;
  assign o_err        = r_err;
  assign o_busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed self-checking bench for dma_cmd_queue (DEPTH=4, TIMEOUT=64, CW=8).
module tb_dma_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_desc = '0;
  logic [1:0]  push_cmd = '0;
  logic        push_ready;
  logic [31:0] dma_desc;
  logic [1:0]  dma_cmd;
  logic        dreq;
  logic        ddone = 1'b0;
  logic        busy;
  logic [2:0]  level;
  logic [7:0]  done_cnt;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_cmd_queue #(
    .DEPTH   (4),
    .TIMEOUT (64),
    .CW      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (push_valid),
    .i_push_desc  (push_desc),
    .i_push_cmd   (push_cmd),
    .o_push_ready (push_ready),
    .o_dma_desc   (dma_desc),
    .o_dma_cmd    (dma_cmd),
    .o_dreq       (dreq),
    .i_ddone      (ddone),
    .o_busy       (busy),
    .o_level      (level),
    .o_done_cnt   (done_cnt),
    .o_err        (err),
    .i_err_clr    (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    push_valid = 1'b0;
    ddone      = 1'b0;
    err_clr    = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] c);
    push_valid = 1'b1;
    push_desc  = d;
    push_cmd   = c;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_dreq(output bit ok);
    int n = 0;
    while (!dreq && n < 200) begin
      tick();
      n++;
    end
    ok = dreq;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (dreq !== 1'b0) begin failures++; $display("FAIL rst_dreq: got %b exp 0", dreq); end
    checks++; if (dma_desc !== 32'h0) begin failures++; $display("FAIL rst_desc: got %h exp 0", dma_desc); end
    checks++; if (dma_cmd !== 2'b00) begin failures++; $display("FAIL rst_cmd: got %b exp 00", dma_cmd); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL rst_done: got %0d exp 0", done_cnt); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL rst_err: got %b exp 00", err); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level: got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b exp 1", push_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    push(32'h0400_4046, 2'b00);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level1: got %0d exp 1", level); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy1: got %b exp 1", busy); end
    tick();
    checks++; if (dma_desc !== 32'h0400_4046) begin failures++; $display("FAIL single_desc: got %h exp 04004046", dma_desc); end
    checks++; if (dreq !== 1'b0) begin failures++; $display("FAIL single_setup: got %b exp 0", dreq); end
    tick();
    checks++; if (dreq !== 1'b1) begin failures++; $display("FAIL single_rise: got %b exp 1", dreq); end
    tick();
    tick();
    checks++; if (dreq !== 1'b1) begin failures++; $display("FAIL single_hold: got %b exp 1", dreq); end
    ddone = 1'b1;
    tick();
    ddone = 1'b0;
    checks++; if (dreq !== 1'b0) begin failures++; $display("FAIL single_fall: got %b exp 0", dreq); end
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("FAIL single_done: got %0d exp 1", done_cnt); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level0: got %0d exp 0", level); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [5];
    logic [1:0]  c [4];
    bit ok;
    d[0] = 32'h0800_2001; d[1] = 32'h0C00_4002; d[2] = 32'h1000_6003;
    d[3] = 32'h1400_8004; d[4] = 32'h1800_A005;
    c[0] = 2'b00; c[1] = 2'b01; c[2] = 2'b10; c[3] = 2'b11;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_desc  = d[i];
      push_cmd   = c[i];
      tick();
    end
    push_desc = d[4];
    push_cmd  = 2'b00;
    checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready: got %b exp 0", push_ready); end
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL b2b_level4: got %0d exp 4", level); end
    tick();
    push_valid = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL b2b_no_fifth: got %0d exp 4", level); end
    for (int i = 0; i < 4; i++) begin
      wait_dreq(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_dreq%0d: got 0 exp 1", i); end
      checks++; if (dma_desc !== d[i] || dma_cmd !== c[i]) begin
        failures++; $display("FAIL b2b_order%0d: got %h/%b exp %h/%b", i, dma_desc, dma_cmd, d[i], c[i]);
      end
      ddone = 1'b1;
      tick();
      ddone = 1'b0;
      checks++; if (dreq !== 1'b0) begin failures++; $display("FAIL b2b_gap%0d: got %b exp 0", i, dreq); end
    end
    tick();
    checks++; if (done_cnt !== 8'd4) begin failures++; $display("FAIL b2b_done: got %0d exp 4", done_cnt); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL b2b_empty: got %0d exp 0", level); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL b2b_err: got %b exp 00", err); end
  endtask

  task automatic test_hung();
    bit ok;
    int n = 0;
    apply_reset();
    push(32'h0800_2001, 2'b00);
    push(32'h0C00_4002, 2'b01);
    wait_dreq(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hung_rise: got 0 exp 1"); end
    while (dreq && n < 200) begin
      n++;
      tick();
    end
    checks++; if (n !== 64) begin failures++; $display("FAIL hung_width: got %0d exp 64", n); end
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL hung_err: got %b exp 01", err); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL hung_done0: got %0d exp 0", done_cnt); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL hung_drop: got %0d exp 1", level); end
    wait_dreq(ok);
    checks++; if (!ok || dma_desc !== 32'h0C00_4002) begin
      failures++; $display("FAIL hung_next: got %b/%h exp 1/0c004002", ok, dma_desc);
    end
    ddone = 1'b1;
    tick();
    ddone = 1'b0;
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("FAIL hung_done1: got %0d exp 1", done_cnt); end
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL hung_sticky: got %b exp 01", err); end
  endtask

  task automatic test_zero_count();
    int n_high = 0;
    apply_reset();
    push(32'h0000_4046, 2'b00);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL zero_level: got %0d exp 0", level); end
    checks++; if (err !== 2'b10) begin failures++; $display("FAIL zero_err: got %b exp 10", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b exp 0", busy); end
    repeat (6) begin
      if (dreq) n_high++;
      tick();
    end
    checks++; if (n_high !== 0) begin failures++; $display("FAIL zero_nodreq: got %0d exp 0", n_high); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL zero_done: got %0d exp 0", done_cnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL zero_clr: got %b exp 00", err); end
    err_clr = 1'b1;
    push(32'h0000_0001, 2'b00);
    err_clr = 1'b0;
    checks++; if (err !== 2'b10) begin failures++; $display("FAIL zero_set_prio: got %b exp 10", err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    push(32'h0400_0001, 2'b00);
    push(32'h0400_0002, 2'b00);
    push(32'h0400_0003, 2'b00);
    wait_dreq(ok);
    checks++; if (!ok || level !== 3'd3) begin failures++; $display("FAIL rmid_pre: got %b/%0d exp 1/3", ok, level); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dreq !== 1'b0) begin failures++; $display("FAIL rmid_dreq: got %b exp 0", dreq); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rmid_level: got %0d exp 0", level); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b exp 1", push_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ddone = 1'b1;
    tick();
    tick();
    ddone = 1'b0;
    tick();
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL rmid_stray: got %0d exp 0", done_cnt); end
    checks++; if (dreq !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_idle: got %b/%b exp 0/0", dreq, busy);
    end
  endtask

  task automatic test_ddone_hold();
    bit ok;
    int n_high = 0;
    apply_reset();
    push(32'h0400_1111, 2'b00);
    push(32'h0800_2222, 2'b01);
    wait_dreq(ok);
    checks++; if (!ok || dma_desc !== 32'h0400_1111) begin
      failures++; $display("FAIL hold_first: got %b/%h exp 1/04001111", ok, dma_desc);
    end
    ddone = 1'b1;
    repeat (3) begin
      tick();
      if (dreq) n_high++;
    end
    ddone = 1'b0;
    checks++; if (n_high !== 0) begin failures++; $display("FAIL hold_gap: got %0d exp 0", n_high); end
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("FAIL hold_once: got %0d exp 1", done_cnt); end
    tick();
    checks++; if (dreq !== 1'b0 || dma_desc !== 32'h0800_2222) begin
      failures++; $display("FAIL hold_load: got %b/%h exp 0/08002222", dreq, dma_desc);
    end
    tick();
    checks++; if (dreq !== 1'b1) begin failures++; $display("FAIL hold_rise: got %b exp 1", dreq); end
    ddone = 1'b1;
    tick();
    ddone = 1'b0;
    checks++; if (done_cnt !== 8'd2) begin failures++; $display("FAIL hold_done2: got %0d exp 2", done_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    int misses = 0;
    logic [7:0] cnt_255 = '0;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      push(32'h0400_0000 | 32'(i), 2'b00);
      wait_dreq(ok);
      if (!ok) misses++;
      ddone = 1'b1;
      tick();
      ddone = 1'b0;
      if (i == 254) cnt_255 = done_cnt;
    end
    checks++; if (misses !== 0) begin failures++; $display("FAIL wrap_dreq: got %0d misses exp 0", misses); end
    checks++; if (cnt_255 !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d exp 255", cnt_255); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d exp 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hung();
    test_zero_count();
    test_reset_mid();
    test_ddone_hold();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
